// File: rtl/regwrite_trace_unit.sv
// Commit-trace engine: timestamps register-file writes from up to NUM_CH channels, buffers
// them in a FIFO and streams them over valid/ready. On halt it drains the FIFO, dumps
// R1..R(2^ADDR_W-1) through the register-file read port and finishes with an END record.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   we/dst_addr/dst   per-channel write enable, destination and data (ch0 in LSBs)
//   hlt               core halt level, sampled only while running
//   rf_rd_addr/_data  register-file read port used during the dump
//   out_*             trace record (kind 0=WRITE, 1=REG, 2=END) with valid/ready handshake
//   drop_cnt          saturating count of writes lost to a full FIFO
//   done              high once the END record has been accepted
module regwrite_trace_unit #(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CYC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] dst_addr,
    input  logic [NUM_CH*DATA_W-1:0] dst,
    input  logic                     hlt,
    output logic [ADDR_W-1:0]        rf_rd_addr,
    input  logic [DATA_W-1:0]        rf_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [1:0]               out_ch,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [7:0]               drop_cnt,
    output logic                     done
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] KindWrite = 2'd0;
    localparam logic [1:0] KindReg   = 2'd1;
    localparam logic [1:0] KindEnd   = 2'd2;

    typedef enum logic [2:0] {StRun, StDrain, StDump, StEndRec, StDone} state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic [CYC_W-1:0]   halt_cyc_q, halt_cyc_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         drop_q, drop_d;

    // FIFO storage; contents are only observed through the head when count_q != 0.
    logic [1:0]         ch_mem   [DEPTH];
    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [CYC_W-1:0]   cyc_mem  [DEPTH];

    logic [NUM_CH-1:0]  push_en;
    logic [PTR_W-1:0]   push_idx [NUM_CH];
    int unsigned        n_push;
    int unsigned        n_drop;
    int unsigned        drop_sum;
    logic               fifo_state;
    logic               pop;

    assign fifo_state = (state_q == StRun) || (state_q == StDrain);
    assign pop        = fifo_state && (count_q != '0) && out_ready;

    // Free slots are judged against the start-of-cycle count, so lower channels take the
    // available room first and a same-cycle pop never makes extra space.
    always_comb begin
        push_en = '0;
        n_push  = 0;
        n_drop  = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            push_idx[ch] = '0;
        end
        if (state_q == StRun) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (we[ch]) begin
                    if (n_push < (DEPTH - int'(count_q))) begin
                        push_en[ch]  = 1'b1;
                        push_idx[ch] = PTR_W'((int'(wr_ptr_q) + n_push) % DEPTH);
                        n_push       = n_push + 1;
                    end else begin
                        n_drop = n_drop + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = PTR_W'((int'(wr_ptr_q) + n_push) % DEPTH);
        rd_ptr_d = pop ? PTR_W'((int'(rd_ptr_q) + 1) % DEPTH) : rd_ptr_q;
        count_d  = CNT_W'(int'(count_q) + n_push - (pop ? 1 : 0));
        drop_sum = int'(drop_q) + n_drop;
        drop_d   = (drop_sum > 255) ? 8'd255 : drop_sum[7:0];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        halt_cyc_d = halt_cyc_q;
        cycle_d    = (state_q == StRun) ? cycle_q + 1'b1 : cycle_q;
        unique case (state_q)
            StRun: begin
                if (hlt) begin
                    state_d    = StDrain;
                    halt_cyc_d = cycle_q;
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    state_d = StDump;
                    idx_d   = ADDR_W'(1);
                end
            end
            StDump: begin
                if (out_ready) begin
                    if (idx_q == '1) begin
                        state_d = StEndRec;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StEndRec: begin
                if (out_ready) begin
                    state_d = StDone;
                end
            end
            StDone: ;
            default: state_d = StRun;
        endcase
    end

    // Every field is forced to zero unless it belongs to the record being presented.
    always_comb begin
        out_valid  = 1'b0;
        out_kind   = KindWrite;
        out_ch     = 2'd0;
        out_addr   = '0;
        out_data   = '0;
        out_cycle  = '0;
        rf_rd_addr = '0;
        done       = 1'b0;
        unique case (state_q)
            StRun, StDrain: begin
                if (count_q != '0) begin
                    out_valid = 1'b1;
                    out_ch    = ch_mem[rd_ptr_q];
                    out_addr  = addr_mem[rd_ptr_q];
                    out_data  = data_mem[rd_ptr_q];
                    out_cycle = cyc_mem[rd_ptr_q];
                end
            end
            StDump: begin
                rf_rd_addr = idx_q;
                out_valid  = 1'b1;
                out_kind   = KindReg;
                out_addr   = idx_q;
                out_data   = rf_rd_data;
            end
            StEndRec: begin
                out_valid = 1'b1;
                out_kind  = KindEnd;
                out_cycle = halt_cyc_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign drop_cnt = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            cycle_q    <= '0;
            halt_cyc_q <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            halt_cyc_q <= halt_cyc_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (push_en[ch]) begin
                ch_mem[push_idx[ch]]   <= 2'(ch);
                addr_mem[push_idx[ch]] <= dst_addr[ch*ADDR_W +: ADDR_W];
                data_mem[push_idx[ch]] <= dst[ch*DATA_W +: DATA_W];
                cyc_mem[push_idx[ch]]  <= cycle_q;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_trace_unit.sv
module tb_regwrite_trace_unit;

    localparam int NCH = 2;
    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int CW  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    we = '0;
    logic [NCH*AW-1:0] dst_addr = '0;
    logic [NCH*DW-1:0] dst = '0;
    logic              hlt = 1'b0;
    logic [AW-1:0]     rf_rd_addr;
    logic [DW-1:0]     rf_rd_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_kind;
    logic [1:0]        out_ch;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_cycle;
    logic [7:0]        drop_cnt;
    logic              done;

    logic [DW-1:0] rf [16];
    assign rf_rd_data = rf[rf_rd_addr];

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]    rec_kind [64];
    logic [AW-1:0] rec_addr [64];
    logic [DW-1:0] rec_data [64];
    logic [CW-1:0] rec_cyc  [64];
    int            n_rec;

    always #5 clk = ~clk;

    regwrite_trace_unit #(
        .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .CYC_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .dst_addr(dst_addr), .dst(dst), .hlt(hlt),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_ch(out_ch), .out_addr(out_addr),
        .out_data(out_data), .out_cycle(out_cycle), .drop_cnt(drop_cnt), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 with reset released on a falling edge.
    task automatic do_reset();
        rst = 1'b1; we = '0; hlt = 1'b0; dst = '0; dst_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[ch] = 1'b1;
        dst_addr[ch*AW +: AW] = a;
        dst[ch*DW +: DW] = d;
    endtask

    task automatic collect(input int max_cyc);
        bit got_done = 1'b0;
        n_rec = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (out_valid && out_ready && n_rec < 64) begin
                rec_kind[n_rec] = out_kind;
                rec_addr[n_rec] = out_addr;
                rec_data[n_rec] = out_data;
                rec_cyc[n_rec]  = out_cycle;
                n_rec++;
            end
            step();
            we = '0;
        end
        check("done_reached", 64'(got_done), 64'd1);
    endtask

    task automatic check_dump(input int first, input logic [CW-1:0] halt_cyc);
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("reg%0d_kind", i), 64'(rec_kind[first+i-1]), 64'd1);
            check($sformatf("reg%0d_addr", i), 64'(rec_addr[first+i-1]), 64'(i));
            check($sformatf("reg%0d_data", i), 64'(rec_data[first+i-1]), 64'(16'h1000 + i));
            check($sformatf("reg%0d_cyc", i), 64'(rec_cyc[first+i-1]), 64'd0);
        end
        check("end_kind", 64'(rec_kind[first+15]), 64'd2);
        check("end_addr", 64'(rec_addr[first+15]), 64'd0);
        check("end_cycle", 64'(rec_cyc[first+15]), 64'(halt_cyc));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);

        // Reset state
        do_reset();
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_rdaddr", 64'(rf_rd_addr), 64'd0);
        check("rst_cycle", 64'(out_cycle), 64'd0);

        // 1: single write at cycle 5
        out_ready = 1'b1;
        repeat (5) step();
        set_wr(0, 4'd3, 16'hBEEF);
        step();
        we = '0;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_kind", 64'(out_kind), 64'd0);
        check("t1_ch", 64'(out_ch), 64'd0);
        check("t1_addr", 64'(out_addr), 64'd3);
        check("t1_data", 64'(out_data), 64'hBEEF);
        check("t1_cycle", 64'(out_cycle), 64'd5);
        step();
        check("t1_empty", 64'(out_valid), 64'd0);

        // 2: two channels in cycle 7, ch0 first
        do_reset();
        out_ready = 1'b1;
        repeat (7) step();
        set_wr(0, 4'd1, 16'h0011);
        set_wr(1, 4'd2, 16'h0022);
        step();
        we = '0;
        check("t2a_ch", 64'(out_ch), 64'd0);
        check("t2a_addr", 64'(out_addr), 64'd1);
        check("t2a_data", 64'(out_data), 64'h0011);
        check("t2a_cycle", 64'(out_cycle), 64'd7);
        step();
        check("t2b_valid", 64'(out_valid), 64'd1);
        check("t2b_ch", 64'(out_ch), 64'd1);
        check("t2b_addr", 64'(out_addr), 64'd2);
        check("t2b_data", 64'(out_data), 64'h0022);
        check("t2b_cycle", 64'(out_cycle), 64'd7);
        step();
        check("t2_empty", 64'(out_valid), 64'd0);

        // 3: overflow with stalled consumer, depth 4
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            we = '0;
            set_wr(0, 4'(i + 1), 16'h00A0 + 16'(i));
            step();
        end
        we = '0;
        check("t3_drop", 64'(drop_cnt), 64'd2);
        for (int k = 0; k < 2; k++) begin
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_addr", 64'(out_addr), 64'd1);
            check("t3_hold_data", 64'(out_data), 64'h00A0);
            check("t3_hold_cycle", 64'(out_cycle), 64'd0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("t3_%0d_addr", k), 64'(out_addr), 64'(k + 1));
            check($sformatf("t3_%0d_data", k), 64'(out_data), 64'(16'h00A0 + k));
            check($sformatf("t3_%0d_cycle", k), 64'(out_cycle), 64'(k));
            step();
        end
        check("t3_empty", 64'(out_valid), 64'd0);

        // 4: halt at cycle 20 with two pending writes
        do_reset();
        out_ready = 1'b0;
        repeat (10) step();
        set_wr(0, 4'd5, 16'h0055);
        step();
        set_wr(0, 4'd6, 16'h0066);
        step();
        we = '0;
        repeat (8) step();
        hlt = 1'b1;
        step();
        hlt = 1'b0;
        out_ready = 1'b1;
        collect(100);
        check("t4_nrec", 64'(n_rec), 64'd18);
        check("t4_w0_kind", 64'(rec_kind[0]), 64'd0);
        check("t4_w0_addr", 64'(rec_addr[0]), 64'd5);
        check("t4_w0_cyc", 64'(rec_cyc[0]), 64'd10);
        check("t4_w1_addr", 64'(rec_addr[1]), 64'd6);
        check("t4_w1_data", 64'(rec_data[1]), 64'h0066);
        check("t4_w1_cyc", 64'(rec_cyc[1]), 64'd11);
        check_dump(2, 32'd20);
        check("t4_valid_after", 64'(out_valid), 64'd0);

        // 5: halt and write together; later write ignored
        do_reset();
        out_ready = 1'b1;
        repeat (9) step();
        set_wr(0, 4'd4, 16'hCAFE);
        hlt = 1'b1;
        step();
        hlt = 1'b0;
        we = '0;
        set_wr(0, 4'd7, 16'h7777);
        collect(100);
        check("t5_nrec", 64'(n_rec), 64'd17);
        check("t5_w_kind", 64'(rec_kind[0]), 64'd0);
        check("t5_w_addr", 64'(rec_addr[0]), 64'd4);
        check("t5_w_data", 64'(rec_data[0]), 64'hCAFE);
        check("t5_w_cyc", 64'(rec_cyc[0]), 64'd9);
        check_dump(1, 32'd9);

        // 6: reset during dump at idx 6
        do_reset();
        out_ready = 1'b0;
        repeat (2) step();
        hlt = 1'b1;
        step();
        hlt = 1'b0;
        step();
        check("t6_dump_kind", 64'(out_kind), 64'd1);
        check("t6_dump_addr", 64'(out_addr), 64'd1);
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        check("t6_idx6_addr", 64'(out_addr), 64'd6);
        check("t6_idx6_rd", 64'(rf_rd_addr), 64'd6);
        check("t6_idx6_data", 64'(out_data), 64'h1006);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_kind", 64'(out_kind), 64'd0);
        check("t6_rst_addr", 64'(out_addr), 64'd0);
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_rd", 64'(rf_rd_addr), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        do_reset();
        out_ready = 1'b1;
        repeat (3) step();
        set_wr(0, 4'd9, 16'h9999);
        step();
        we = '0;
        check("t6_new_valid", 64'(out_valid), 64'd1);
        check("t6_new_kind", 64'(out_kind), 64'd0);
        check("t6_new_addr", 64'(out_addr), 64'd9);
        check("t6_new_cycle", 64'(out_cycle), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
